// File: rtl/i2c_sensor_responder_if.sv
// Bus and host-side signal bundle for the I2C sensor responder.
// The I2C pad pins, the host load port and the initiator write strobe port are grouped here.
interface i2c_sensor_responder_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic       ld_en;
  logic [3:0] ld_addr;
  logic [7:0] ld_data;
  logic       wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  modport slave (
    input  scl_in, sda_in, ld_en, ld_addr, ld_data,
    output sda_oe, wr_stb, wr_addr, wr_data, busy
  );

  modport master (
    output scl_in, sda_in, ld_en, ld_addr, ld_data,
    input  sda_oe, wr_stb, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/i2c_sensor_responder.sv
// I2C target emulating a 16-byte inertial sensor register file (reg[15] = ID, read-only).
// Optional: define I2C_RESP_GLITCH_FILTER_EN for a 3-sample majority filter on SCL/SDA.
//
// Handshakes: ld_en is a single-cycle strobe with no backpressure; the load is
// always accepted on that edge.  wr_stb is a one-cycle valid with no ready, and
// wr_addr/wr_data hold until the next initiator write.
module i2c_sensor_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h68
) (
  input  logic                  sysclk,
  input  logic                  nsysreset,
  i2c_sensor_responder_if.slave bus,
  output logic [3:0]            dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK
  } state_t;

  logic [1:0] scl_sync, sda_sync;
  logic       scl_f, sda_f, scl_q, sda_q;

  always_ff @(posedge sysclk or negedge nsysreset) begin
    if (!nsysreset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl_in};
      sda_sync <= {sda_sync[0], bus.sda_in};
    end
  end

`ifdef I2C_RESP_GLITCH_FILTER_EN
  logic [2:0] scl_hist, sda_hist;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  always_ff @(posedge sysclk or negedge nsysreset) begin
    if (!nsysreset) begin
      scl_hist <= 3'b111;
      sda_hist <= 3'b111;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[1:0], scl_sync[1]};
      sda_hist <= {sda_hist[1:0], sda_sync[1]};
      scl_f    <= maj3(scl_hist);
      sda_f    <= maj3(sda_hist);
    end
  end
`else
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  always_ff @(posedge sysclk or negedge nsysreset) begin
    if (!nsysreset) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_c, stop_c;
  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start_c  = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_c   = scl_f & scl_q & ~sda_q & sda_f;

  state_t     state, state_d;
  logic       phase, phase_d;   // ACK states: 0 = waiting for end of bit 8, 1 = driving ACK
  logic [2:0] cnt, cnt_d;
  logic [7:0] tx, tx_d;
  logic [6:0] sr;               // last seven received bits; byte_in appends the current one
  logic       ack_q;
  logic [3:0] ptr;
  logic [7:0] regs [0:15];
  logic       sda_oe_d;

  logic [7:0] byte_in, rd_byte;
  logic       last_bit, addr_hit, wr_fire;
  assign byte_in  = {sr, sda_f};
  assign rd_byte  = regs[ptr];
  assign last_bit = scl_rise & (cnt == 3'd7);
  assign addr_hit = (byte_in[7:1] == DEV_ADDR);
  assign wr_fire  = (state == S_WR_DATA) & last_bit;

  // State register
  always_ff @(posedge sysclk or negedge nsysreset) begin
    if (!nsysreset) begin
      state      <= S_IDLE;
      phase      <= 1'b0;
      cnt        <= 3'd0;
      tx         <= 8'h00;
      bus.sda_oe <= 1'b0;
    end else begin
      state      <= state_d;
      phase      <= phase_d;
      cnt        <= cnt_d;
      tx         <= tx_d;
      bus.sda_oe <= sda_oe_d;
    end
  end

  // Next-state logic; START/STOP override everything
  always_comb begin
    state_d = state;
    phase_d = phase;
    cnt_d   = cnt;
    tx_d    = tx;
    if (stop_c) begin
      state_d = S_IDLE;
    end else if (start_c) begin
      state_d = S_ADDR;
      cnt_d   = 3'd0;
    end else begin
      case (state)
        S_ADDR, S_PTR, S_WR_DATA: begin
          if (scl_rise) begin
            cnt_d = cnt + 3'd1;
            if (cnt == 3'd7) begin
              phase_d = 1'b0;
              if (state == S_ADDR)     state_d = addr_hit ? S_ADDR_ACK : S_IDLE;
              else if (state == S_PTR) state_d = S_PTR_ACK;
              else                     state_d = S_WR_ACK;
            end
          end
        end
        S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
          if (scl_fall) begin
            if (!phase) begin
              phase_d = 1'b1;
            end else begin
              cnt_d = 3'd0;
              if (state == S_ADDR_ACK && sr[0]) begin
                state_d = S_RD_DATA;
                tx_d    = rd_byte;
              end else if (state == S_ADDR_ACK) begin
                state_d = S_PTR;
              end else begin
                state_d = S_WR_DATA;
              end
            end
          end
        end
        S_RD_DATA: begin
          if (scl_fall) begin
            if (cnt == 3'd7) begin
              state_d = S_RD_ACK;
            end else begin
              cnt_d = cnt + 3'd1;
              tx_d  = {tx[6:0], 1'b0};
            end
          end
        end
        S_RD_ACK: begin
          if (scl_fall) begin
            if (ack_q) begin
              state_d = S_RD_DATA;
              tx_d    = rd_byte;
              cnt_d   = 3'd0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic: evaluated on next state so SDA moves exactly one cycle after the SCL fall
  always_comb begin
    sda_oe_d = 1'b0;
    case (state_d)
      S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: sda_oe_d = phase_d;
      S_RD_DATA:                       sda_oe_d = ~tx_d[7];
      default:                         sda_oe_d = 1'b0;
    endcase
  end

  // Datapath: shift register, pointer, register file, write strobe, busy flag
  always_ff @(posedge sysclk or negedge nsysreset) begin
    if (!nsysreset) begin
      sr          <= 7'h00;
      ack_q       <= 1'b0;
      ptr         <= 4'd0;
      bus.wr_stb  <= 1'b0;
      bus.wr_addr <= 4'd0;
      bus.wr_data <= 8'h00;
      bus.busy    <= 1'b0;
      for (int i = 0; i < 15; i++) regs[i] <= 8'h00;
      regs[15]    <= {1'b0, DEV_ADDR};
    end else begin
      bus.wr_stb <= wr_fire;
      if (scl_rise && (state == S_ADDR || state == S_PTR || state == S_WR_DATA))
        sr <= byte_in[6:0];
      if (state == S_PTR && last_bit)
        ptr <= byte_in[3:0];
      if (wr_fire) begin
        ptr         <= ptr + 4'd1;
        bus.wr_addr <= ptr;
        bus.wr_data <= byte_in;
        if (ptr != 4'd15) regs[ptr] <= byte_in;
      end
      if (state == S_RD_ACK && scl_rise) begin
        ack_q <= ~sda_f;
        if (!sda_f) ptr <= ptr + 4'd1;
      end
      // Host load is written last so it wins a same-index collision
      if (bus.ld_en && bus.ld_addr != 4'd15)
        regs[bus.ld_addr] <= bus.ld_data;
      if (stop_c)
        bus.busy <= 1'b0;
      else if (state == S_ADDR && last_bit && addr_hit)
        bus.busy <= 1'b1;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_i2c_sensor_responder.sv
// Self-checking bench for i2c_sensor_responder: bit-banged I2C initiator, host loader,
// and queue-based scoreboards for initiator writes and read data.
module tb_i2c_sensor_responder;
  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [3:0] dbg_state;

  int checks = 0;
  int failures = 0;
  int oe_hi_changes = 0;
  logic prev_oe = 1'b0;
  logic watch = 1'b0;
  logic seen_oe = 1'b0;
  logic seen_busy = 1'b0;

  logic [11:0] wr_exp_q[$];
  logic [7:0]  rd_exp_q[$];

  i2c_sensor_responder_if bus();

  assign bus.scl_in = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;

  i2c_sensor_responder dut (
    .sysclk    (clk),
    .nsysreset (nrst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #50 clk = ~clk;

  // Write-strobe scoreboard and bus-rule monitors
  always @(negedge clk) begin
    if (nrst && bus.wr_stb) begin
      checks++;
      if (wr_exp_q.size() == 0) begin
        failures++;
        $display("FAIL wr_stb_unexpected got=%h/%h expected=none", bus.wr_addr, bus.wr_data);
      end else begin
        logic [11:0] e;
        e = wr_exp_q.pop_front();
        if ({bus.wr_addr, bus.wr_data} !== e) begin
          failures++;
          $display("FAIL wr_event got=%h/%h expected=%h/%h", bus.wr_addr, bus.wr_data, e[11:8], e[7:0]);
        end
      end
    end
    if (nrst && scl_m && bus.sda_oe !== prev_oe) oe_hi_changes++;
    prev_oe = bus.sda_oe;
    if (watch && bus.sda_oe) seen_oe = 1'b1;
    if (watch && bus.busy)   seen_busy = 1'b1;
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_load(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.ld_en = 1'b1; bus.ld_addr = a; bus.ld_data = d;
    @(negedge clk);
    bus.ld_en = 1'b0;
  endtask

  task automatic i2c_start();
    if (!scl_m) begin
      sda_m = 1'b1; hold(HALF);
      scl_m = 1'b1; hold(HALF);
    end
    sda_m = 1'b0; hold(HALF);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; hold(HALF);
    scl_m = 1'b1; hold(HALF);
    sda_m = 1'b1; hold(HALF);
  endtask

  task automatic write_bit(input logic b);
    hold(HALF / 2); sda_m = b; hold(HALF / 2);
    scl_m = 1'b1; hold(HALF);
    scl_m = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    hold(HALF / 2); sda_m = 1'b1; hold(HALF / 2);
    scl_m = 1'b1; hold(HALF / 2);
    b = bus.sda_in;
    hold(HALF / 2);
    scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(input logic send_ack, output logic [7:0] d);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(~send_ack);
  endtask

  task automatic test_reset();
    nrst = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    bus.ld_en = 1'b0; bus.ld_addr = 4'd0; bus.ld_data = 8'h00;
    hold(3);
    checks++;
    if ({bus.sda_oe, bus.wr_stb, bus.wr_addr, bus.wr_data, bus.busy} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b%b/%h/%h/%b expected=0", bus.sda_oe, bus.wr_stb, bus.wr_addr, bus.wr_data, bus.busy);
    end
    nrst = 1'b1;
    hold(5);
    checks++;
    if (dbg_state !== 4'd0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got=%0d/%b expected=0/0", dbg_state, bus.busy);
    end
  endtask

  task automatic test_write();
    logic ack;
    logic [7:0] d;
    logic [3:0] acks;
    i2c_start();
    write_byte(8'hD0, acks[0]);
    write_byte(8'h03, acks[1]);
    wr_exp_q.push_back({4'd3, 8'hA5});
    write_byte(8'hA5, acks[2]);
    wr_exp_q.push_back({4'd4, 8'h5A});
    write_byte(8'h5A, acks[3]);
    i2c_stop();
    checks++;
    if (acks !== 4'b1111) begin
      failures++;
      $display("FAIL write_acks got=%b expected=1111", acks);
    end
    checks++;
    if (bus.wr_addr !== 4'd4 || bus.wr_data !== 8'h5A) begin
      failures++;
      $display("FAIL write_hold got=%h/%h expected=4/5a", bus.wr_addr, bus.wr_data);
    end
    i2c_start();
    write_byte(8'hD0, ack);
    write_byte(8'h03, ack);
    i2c_start();
    write_byte(8'hD1, ack);
    rd_exp_q.push_back(8'hA5);
    rd_exp_q.push_back(8'h5A);
    for (int i = 0; i < 2; i++) begin
      logic [7:0] e;
      read_byte(i == 0, d);
      e = rd_exp_q.pop_front();
      checks++;
      if (d !== e) begin
        failures++;
        $display("FAIL write_readback[%0d] got=%h expected=%h", i, d, e);
      end
    end
    i2c_stop();
  endtask

  task automatic test_wrap();
    logic ack;
    logic [7:0] d;
    i2c_start();
    write_byte(8'hD0, ack);
    write_byte(8'h0F, ack);
    wr_exp_q.push_back({4'd15, 8'hFF});
    write_byte(8'hFF, ack);
    checks++;
    if (ack !== 1'b1) begin
      failures++;
      $display("FAIL wrap_ro_write_ack got=%b expected=1", ack);
    end
    i2c_start();
    write_byte(8'hD0, ack);
    write_byte(8'h0F, ack);
    i2c_start();
    write_byte(8'hD1, ack);
    rd_exp_q.push_back(8'h68);
    rd_exp_q.push_back(8'h00);
    for (int i = 0; i < 2; i++) begin
      logic [7:0] e;
      read_byte(i == 0, d);
      e = rd_exp_q.pop_front();
      checks++;
      if (d !== e) begin
        failures++;
        $display("FAIL wrap_read[%0d] got=%h expected=%h", i, d, e);
      end
    end
    i2c_stop();
  endtask

  task automatic test_host_read();
    logic ack;
    logic [7:0] d;
    host_load(4'd0, 8'h12);
    host_load(4'd1, 8'h34);
    i2c_start();
    write_byte(8'hD0, ack);
    write_byte(8'h00, ack);
    i2c_start();
    write_byte(8'hD1, ack);
    checks++;
    if (ack !== 1'b1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL host_read_addr got=ack%b/busy%b expected=1/1", ack, bus.busy);
    end
    rd_exp_q.push_back(8'h12);
    rd_exp_q.push_back(8'h34);
    for (int i = 0; i < 2; i++) begin
      logic [7:0] e;
      read_byte(i == 0, d);
      e = rd_exp_q.pop_front();
      checks++;
      if (d !== e) begin
        failures++;
        $display("FAIL host_read[%0d] got=%h expected=%h", i, d, e);
      end
    end
    hold(HALF / 2);
    checks++;
    if (bus.sda_oe !== 1'b0) begin
      failures++;
      $display("FAIL host_read_release got=%b expected=0", bus.sda_oe);
    end
    i2c_stop();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL host_read_busy_stop got=%b expected=0", bus.busy);
    end
  endtask

  task automatic test_nack_addr();
    logic a0, a1;
    seen_oe = 1'b0; seen_busy = 1'b0; watch = 1'b1;
    i2c_start();
    write_byte(8'hD2, a0);
    write_byte(8'h00, a1);
    i2c_stop();
    watch = 1'b0;
    checks++;
    if ({a0, a1, seen_oe, seen_busy} !== 4'b0000) begin
      failures++;
      $display("FAIL nack_addr got=ack%b%b/oe%b/busy%b expected=all0", a0, a1, seen_oe, seen_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic ack;
    logic [7:0] d;
    logic [7:0] v [3];
    for (int i = 0; i < 3; i++) v[i] = 8'($urandom_range(0, 255));
    i2c_start();
    write_byte(8'hD0, ack);
    write_byte(8'h0E, ack);
    for (int i = 0; i < 3; i++) begin
      wr_exp_q.push_back({4'(14 + i), v[i]});
      write_byte(v[i], ack);
    end
    i2c_start();
    write_byte(8'hD0, ack);
    write_byte(8'h0E, ack);
    i2c_start();
    write_byte(8'hD1, ack);
    rd_exp_q.push_back(v[0]);
    rd_exp_q.push_back(8'h68);
    rd_exp_q.push_back(v[2]);
    for (int i = 0; i < 3; i++) begin
      logic [7:0] e;
      read_byte(i != 2, d);
      e = rd_exp_q.pop_front();
      checks++;
      if (d !== e) begin
        failures++;
        $display("FAIL b2b_read[%0d] got=%h expected=%h", i, d, e);
      end
    end
    i2c_stop();
  endtask

  task automatic test_reset_mid();
    logic ack;
    logic [7:0] d;
    host_load(4'd5, 8'h3C);
    i2c_start();
    write_byte(8'hD0, ack);
    write_byte(8'h05, ack);
    i2c_start();
    write_byte(8'hD1, ack);
    hold(HALF / 2);
    checks++;
    if (bus.sda_oe !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_driving got=%b expected=1", bus.sda_oe);
    end
    @(negedge clk);
    nrst = 1'b0;
    #1;
    checks++;
    if (bus.sda_oe !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_release got=%b expected=0", bus.sda_oe);
    end
    scl_m = 1'b1; hold(2);
    sda_m = 1'b1; hold(HALF);
    nrst = 1'b1; hold(HALF);
    checks++;
    if (bus.busy !== 1'b0 || dbg_state !== 4'd0) begin
      failures++;
      $display("FAIL reset_mid_state got=%b/%0d expected=0/0", bus.busy, dbg_state);
    end
    host_load(4'd0, 8'h77);
    i2c_start();
    write_byte(8'hD1, ack);
    rd_exp_q.push_back(8'h77);
    read_byte(1'b0, d);
    begin
      logic [7:0] e;
      e = rd_exp_q.pop_front();
      checks++;
      if (ack !== 1'b1 || d !== e) begin
        failures++;
        $display("FAIL reset_mid_after got=ack%b/%h expected=1/%h", ack, d, e);
      end
    end
    i2c_stop();
  endtask

`ifdef I2C_RESP_GLITCH_FILTER_EN
  task automatic test_glitch();
    logic ack, b;
    logic [7:0] a;
    a = 8'hD0;
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      if (i == 4) begin
        hold(HALF / 2); sda_m = a[i]; hold(HALF / 2);
        scl_m = 1'b1; hold(HALF / 2);
        scl_m = 1'b0; hold(1);
        scl_m = 1'b1; hold(HALF / 2 - 1);
        scl_m = 1'b0;
      end else begin
        write_bit(a[i]);
      end
    end
    read_bit(b);
    ack = ~b;
    i2c_stop();
    checks++;
    if (ack !== 1'b1) begin
      failures++;
      $display("FAIL glitch_addr_ack got=%b expected=1", ack);
    end
  endtask
`endif

  task automatic test_final();
    hold(5);
    checks++;
    if (wr_exp_q.size() != 0 || rd_exp_q.size() != 0) begin
      failures++;
      $display("FAIL queues_drained got=%0d/%0d expected=0/0", wr_exp_q.size(), rd_exp_q.size());
    end
    checks++;
    if (oe_hi_changes != 0) begin
      failures++;
      $display("FAIL sda_change_scl_high got=%0d expected=0", oe_hi_changes);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wrap();
    test_host_read();
    test_nack_addr();
    test_back_to_back();
    test_reset_mid();
`ifdef I2C_RESP_GLITCH_FILTER_EN
    test_glitch();
`endif
    test_final();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
